// File: rtl/parity_frame_receiver.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Reports each completed frame with a one-cycle rx_valid plus parity/framing error flags.
module parity_frame_receiver #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic             PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               par_bad_q, par_bad_d;
    logic               stop_bit_q, stop_bit_d;
    logic               stop_seen_q, stop_seen_d;
    logic               armed_q, armed_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;
    logic               sync_q, rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= rx;
            rx_s_q <= sync_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        par_bad_d    = par_bad_q;
        stop_bit_d   = stop_bit_q;
        stop_seen_d  = stop_seen_q;
        armed_d      = armed_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                cnt_d       = '0;
                idx_d       = '0;
                stop_seen_d = 1'b0;
                // armed_q blocks a start until the line has been seen high
                // (after reset, or while a break holds the line low)
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    par_bad_d = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[DATA_W-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s_q ^ (^shreg_q) ^ PAR_ODD;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // The counter parks at its last value once the stop bit is
                // captured; the frame is reported on the following edge.
                if (stop_seen_q) begin
                    rx_data_d    = shreg_q;
                    parity_err_d = par_bad_q;
                    frame_err_d  = ~stop_bit_q;
                    rx_valid_d   = 1'b1;
                    armed_d      = stop_bit_q;
                    stop_seen_d  = 1'b0;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    stop_bit_d  = rx_s_q;
                    stop_seen_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bit_q   <= 1'b1;
            stop_seen_q  <= 1'b0;
            armed_q      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            par_bad_q    <= par_bad_d;
            stop_bit_q   <= stop_bit_d;
            stop_seen_q  <= stop_seen_d;
            armed_q      <= armed_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/parity_frame_receiver.md
PARITY_FRAME_RECEIVER -- requirements
Module: parity_frame_receiver

Interface
REQ-001 Parameter DATA_W SHALL default to 8 and set the number of data bits per frame (range 4..16).
REQ-002 Parameter CLKS_PER_BIT SHALL default to 16 and set the clk cycles per serial bit (even value, minimum 4).
REQ-003 Parameter PARITY_ODD SHALL default to 0; 0 selects even parity and 1 selects odd parity.
REQ-004 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, and be an asynchronous, active-high reset.
REQ-006 Port rx SHALL be an input, 1 bit wide, carrying the asynchronous serial line, which idles high.
REQ-007 Port rx_data SHALL be an output, DATA_W bits wide, holding the last received data word.
REQ-008 Port rx_valid SHALL be an output, 1 bit wide, pulsing for one cycle when a frame completes.
REQ-009 Port parity_err SHALL be an output, 1 bit wide, flagging a parity mismatch for the frame reported by rx_valid.
REQ-010 Port frame_err SHALL be an output, 1 bit wide, flagging a stop bit sampled low for the frame reported by rx_valid.
REQ-011 Port busy SHALL be an output, 1 bit wide, and be high whenever the FSM is not in IDLE.

Function
REQ-012 The frame SHALL be: start (0), DATA_W data bits LSB first, one parity bit, one stop (1).
REQ-013 rx SHALL pass through a 2-flop synchronizer (reset value 1); all FSM decisions SHALL use the synchronized value rx_s.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with a bit-period counter and a data-bit index.
REQ-015 In IDLE, rx_s==0 SHALL cause a transition to START and clear the counter.
REQ-016 In START, at count CLKS_PER_BIT/2-1 the FSM SHALL sample rx_s: if 0, go to DATA; if 1 (glitch), return to IDLE with no rx_valid.
REQ-017 In DATA, each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1 (mid-bit), then the counter SHALL reset.
REQ-018 Sampled data bits SHALL shift into a DATA_W shift register LSB first; after bit DATA_W-1 the FSM SHALL go to PARITY.
REQ-019 In PARITY, the bit sampled at mid-bit SHALL be compared with the expected parity, ^data XOR PARITY_ODD; a mismatch SHALL latch an internal parity-error flag; the FSM then goes to STOP.
REQ-020 In STOP, rx_s SHALL be sampled at mid-bit.
REQ-021 On the next edge after the stop sample, the block SHALL load rx_data, parity_err and frame_err (frame_err = stop sample==0), pulse rx_valid for exactly one cycle, and go to IDLE.
REQ-022 rx_valid SHALL fire even when the frame has errors; rx_data SHALL be loaded regardless.
REQ-023 rx_data, parity_err and frame_err SHALL hold their values until the next rx_valid.
REQ-024 If rx_s is still 0 on return to IDLE after a frame_err, the next frame SHALL NOT start until rx_s has returned to 1 (break-hold).
REQ-025 A new start edge MAY be accepted on the first cycle in IDLE after rx_valid; back-to-back frames SHALL be received without loss.
REQ-026 Latency SHALL be: rx_valid asserts 2 (sync) + (DATA_W+2)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 cycles (+/-1) after the rx falling edge.
REQ-027 Counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits; the counter SHALL never wrap within a state.

Reset
REQ-028 While rst=1: FSM = IDLE, counter and index = 0, synchronizer flops = 1, rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
REQ-029 rst asserted mid-frame SHALL abort the frame immediately with no rx_valid.
REQ-030 After rst deasserts, the block SHALL require rx_s==1 for one cycle before accepting a start bit.

Verification
REQ-031 Default parameters; send 0xA5 with parity 0 and stop 1 -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, at the REQ-026 cycle.
REQ-032 Send 0xA5 with parity 1 -> rx_valid, rx_data=0xA5, parity_err=1, frame_err=0.
REQ-033 Send 0x3C with correct parity 0 and stop bit 0 -> rx_valid, frame_err=1; hold rx low for 40 cycles, then high, then send 0x01 -> the second frame is received correctly with no spurious frame in between.
REQ-034 A 4-cycle low glitch on idle rx -> no rx_valid, busy returns to 0, FSM back in IDLE.
REQ-035 Three back-to-back frames 0x00, 0xFF, 0x81 with zero idle between them -> three rx_valid pulses with the correct data and no errors.
REQ-036 Assert rst during data bit 3 of a frame -> outputs go to reset values at once, no rx_valid, and the next full frame is received correctly.
